// File: rtl/alu_ctrl_pkg.sv
// alu_arbiter_ctrl shared definitions.
// Opcodes, FSM encoding, flag indices, C/V helper.
package alu_ctrl_pkg;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MAX_LEGAL = 4'd9;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Returns {C, V} for the arithmetic ops, zero otherwise.
  function automatic logic [1:0] flags_cv(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    logic       c;
    logic       v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    if (op == OP_ADD) begin
      s = {1'b0, a} + {1'b0, b};
      c = s[W];
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end else if (op == OP_SUB || op == OP_CMP) begin
      s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
      c = s[W];
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {c, v};
  endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
// Pointer moves to the loser on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  // Pointer port first, else the other port.
  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      req_i[ptr_q]:
        gnt_o[ptr_q] = 1'b1;
      (!req_i[ptr_q] && req_i[!ptr_q]):
        gnt_o[!ptr_q] = 1'b1;
      default: ;
    endcase
  end

  // A grant is always a handshake here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= ~gnt_o[1];
    end
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one ALU between two ports.
// Option: ALU_ARB_PERF_CNT_EN adds grant counters.
module alu_arbiter_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [3:0]   req_opcode0,
  input  logic [3:0]   req_opcode1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  input  logic [4:0]   req_shift0,
  input  logic [4:0]   req_shift1,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [W-1:0] resp_result,
  output logic [3:0]   resp_flags,
  output logic         resp_err,
  output logic [3:0]   alu_optcode,
  output logic [W-1:0] alu_r2,
  output logic [W-1:0] alu_r3,
  output logic [4:0]   alu_shift,
  input  logic [W-1:0] alu_r1
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  logic [1:0]   state_q, state_d;
  logic         owner_q;
  logic [3:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [4:0]   sh_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] res_q;
  logic [3:0]   flg_q;
  logic         err_q;

  logic [1:0]   gnt;
  logic         hs;
  logic         win;
  logic         cap;
  logic         illegal;
  logic [W-1:0] res_cap;
  logic [3:0]   flg_cap;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req_valid & {2{state_q == IDLE}}),
    .gnt_o   (gnt)
  );

  assign hs      = |gnt;
  assign win     = gnt[1];
  assign illegal = op_q > OP_MAX_LEGAL;
  assign res_cap = illegal ? '0 : alu_r1;
  assign flg_cap = {res_cap[W-1], res_cap == '0,
                    flags_cv(op_q, a_q, b_q)};

  // Sequencing; MUL waits for the counter to drain.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      IDLE:
        if (hs) state_d = EXEC;
      EXEC:
        if (op_q != OP_MUL || cnt_q == 4'd0) begin
          cap     = 1'b1;
          state_d = RESP;
        end
      RESP:
        if (resp_ready[owner_q]) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Operand latch, MUL counter and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= win;
        op_q    <= win ? req_opcode1 : req_opcode0;
        a_q     <= win ? req_a1 : req_a0;
        b_q     <= win ? req_b1 : req_b0;
        sh_q    <= win ? req_shift1 : req_shift0;
        cnt_q   <= CNT_INIT;
      end else if (state_q == EXEC && !cap) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (cap) begin
        res_q <= res_cap;
        flg_q <= flg_cap;
        err_q <= illegal;
      end
    end
  end

  assign req_ready   = gnt;
  assign resp_valid  = {(state_q == RESP) && owner_q,
                        (state_q == RESP) && !owner_q};
  assign resp_result = res_q;
  assign resp_flags  = flg_q;
  assign resp_err    = err_q;
  assign alu_optcode = op_q;
  assign alu_r2      = a_q;
  assign alu_r3      = b_q;
  assign alu_shift   = sh_q;

`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0] gc0_q, gc1_q;

  // Saturating per-port grant counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gc0_q <= '0;
      gc1_q <= '0;
    end else begin
      if (gnt[0] && gc0_q != 16'hFFFF) gc0_q <= gc0_q + 16'd1;
      if (gnt[1] && gc1_q != 16'hFFFF) gc1_q <= gc1_q + 16'd1;
    end
  end

  assign grant_cnt0 = gc0_q;
  assign grant_cnt1 = gc1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: directed + random checks.
// Includes a stub ALU and a reference model.
module tb_alu_arbiter_ctrl;

  localparam int MUL_LAT = 3;
  localparam logic [3:0] T_ADD = 4'd0;
  localparam logic [3:0] T_SUB = 4'd1;
  localparam logic [3:0] T_MUL = 4'd2;
  localparam logic [3:0] T_CMP = 4'd9;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_opcode0, req_opcode1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [4:0]  req_shift0, req_shift1;
  logic [1:0]  resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic [3:0]  resp_flags;
  logic        resp_err;
  logic [3:0]  alu_optcode;
  logic [31:0] alu_r2, alu_r3, alu_r1;
  logic [4:0]  alu_shift;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int gcnt [2];
  logic [3:0]  t_op [2];
  logic [31:0] t_a [2];
  logic [31:0] t_b [2];
  logic [4:0]  t_sh [2];
  int wins [2];

  alu_arbiter_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode0 (req_opcode0),
    .req_opcode1 (req_opcode1),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_b0      (req_b0),
    .req_b1      (req_b1),
    .req_shift0  (req_shift0),
    .req_shift1  (req_shift1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_err    (resp_err),
    .alu_optcode (alu_optcode),
    .alu_r2      (alu_r2),
    .alu_r3      (alu_r3),
    .alu_shift   (alu_shift),
    .alu_r1      (alu_r1)
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] aa;
    aa = {a, a} >> sh;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return a | b;
      4'd4: return a & b;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return a << sh;
      4'd8: return aa[31:0];
      4'd9: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_r1 = alu_ref(alu_optcode, alu_r2, alu_r3, alu_shift);

  function automatic logic [3:0] exp_flags(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] r);
    longint sa, sb, s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    if (op == T_ADD) begin
      c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
      s = sa + sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op == T_SUB || op == T_CMP) begin
      c = a >= b;
      s = sa - sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r[31], r == 32'h0, c, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic transact(input logic [1:0] vm, input int hold);
    int w, n, k, lat;
    logic [1:0] oh;
    logic [31:0] er;
    logic [3:0] ef;
    logic ee;
    req_opcode0 = t_op[0]; req_a0 = t_a[0];
    req_b0 = t_b[0]; req_shift0 = t_sh[0];
    req_opcode1 = t_op[1]; req_a1 = t_a[1];
    req_b1 = t_b[1]; req_shift1 = t_sh[1];
    req_valid = vm;
    #1;
    w = (vm == 2'b11) ? model_ptr : (vm[1] ? 1 : 0);
    oh = 2'(1 << w);
    k = 0;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("grant", req_ready, oh);
    if (req_ready != oh) begin
      req_valid = 2'b00;
      @(negedge clk);
      return;
    end
    model_ptr = 1 - w;
    gcnt[w]++;
    wins[w]++;
    ee = t_op[w] > 4'd9;
    er = ee ? 32'h0 : alu_ref(t_op[w], t_a[w], t_b[w], t_sh[w]);
    ef = exp_flags(t_op[w], t_a[w], t_b[w], er);
    lat = (t_op[w] == T_MUL) ? 1 + MUL_LAT : 2;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid[w] = 1'b0;
      if (resp_valid != 2'b00) break;
      chk("exec_a", alu_r2, t_a[w]);
      chk("exec_b", alu_r3, t_b[w]);
      chk("exec_rdy", req_ready, 2'b00);
    end
    chk("latency", n, lat);
    chk("resp_valid", resp_valid, oh);
    chk("result", resp_result, er);
    chk("flags", resp_flags, ef);
    chk("err", resp_err, ee);
    for (int i = 0; i < hold; i++) begin
      resp_ready = 2'($urandom_range(0, 3));
      resp_ready[w] = 1'b0;
      @(negedge clk);
      chk("hold_valid", resp_valid, oh);
      chk("hold_result", resp_result, er);
      chk("hold_flags", resp_flags, ef);
      chk("hold_err", resp_err, ee);
    end
    resp_ready = 2'b00;
    resp_ready[w] = 1'b1;
    @(negedge clk);
    resp_ready = 2'b00;
    chk("resp_drop", resp_valid, 2'b00);
  endtask

  task automatic set_op(input int p, input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    t_op[p] = op; t_a[p] = a; t_b[p] = b; t_sh[p] = sh;
  endtask

  function automatic logic [31:0] rnd_val();
    int s;
    s = $urandom_range(0, 5);
    if (s == 0) return 32'h8000_0000;
    if (s == 1) return 32'hFFFF_FFFF;
    if (s == 2) return 32'h0;
    return $urandom();
  endfunction

  task automatic rnd_op(input int p);
    logic [3:0] op;
    if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
    else op = 4'($urandom_range(0, 9));
    set_op(p, op, rnd_val(), rnd_val(), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    req_opcode0 = '0; req_opcode1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_shift0 = '0; req_shift1 = '0;
    gcnt[0] = 0; gcnt[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_result", resp_result, 32'h0);
    chk("rst_flags", resp_flags, 4'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_opcode", alu_optcode, 4'h0);
    chk("rst_r2", alu_r2, 32'h0);
    chk("rst_r3", alu_r3, 32'h0);
    chk("rst_shift", alu_shift, 5'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    set_op(0, T_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0);
    transact(2'b01, 0);
    set_op(1, T_SUB, 32'h8000_0000, 32'h1, 5'd0);
    transact(2'b10, 1);
    set_op(1, T_CMP, 32'd5, 32'd5, 5'd0);
    transact(2'b10, 0);
    set_op(0, T_MUL, 32'd7, 32'd6, 5'd0);
    transact(2'b01, 0);
    set_op(1, 4'd12, 32'h1234, 32'h5678, 5'd3);
    transact(2'b10, 5);

    wins[0] = 0; wins[1] = 0;
    for (int i = 0; i < 16; i++) begin
      rnd_op(0);
      rnd_op(1);
      transact(2'b11, $urandom_range(0, 1));
    end
    chk("rr_wins0", wins[0], 8);
    chk("rr_wins1", wins[1], 8);

    set_op(0, T_MUL, 32'd9, 32'd9, 5'd0);
    req_opcode0 = t_op[0]; req_a0 = t_a[0];
    req_b0 = t_b[0]; req_shift0 = t_sh[0];
    req_valid = 2'b01;
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("mr_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mr_req_ready", req_ready, 2'b00);
    chk("mr_resp_valid", resp_valid, 2'b00);
    chk("mr_result", resp_result, 32'h0);
    chk("mr_flags", resp_flags, 4'h0);
    chk("mr_err", resp_err, 1'b0);
    chk("mr_opcode", alu_optcode, 4'h0);
    chk("mr_r2", alu_r2, 32'h0);
    chk("mr_r3", alu_r3, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_ptr = 0;
    gcnt[0] = 0; gcnt[1] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_resp", resp_valid, 2'b00);
    end
    set_op(1, T_ADD, 32'd100, 32'd23, 5'd0);
    transact(2'b10, 0);

    for (int i = 0; i < 30; i++) begin
      rnd_op(0);
      rnd_op(1);
      transact(2'($urandom_range(1, 3)), $urandom_range(0, 2));
    end

`ifdef ALU_ARB_PERF_CNT_EN
    chk("grant_cnt0", grant_cnt0, 16'(gcnt[0]));
    chk("grant_cnt1", grant_cnt1, 16'(gcnt[1]));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
